accum_decoder: RTL and testbench

- Inverse of the running-sum accumulator: takes a stream of accumulated values and recovers the per-sample increments, out[n] = acc[n] - acc[n-1].
- Sits on the checker side of accumulator benches. It regenerates the input sequence from DUT output so a tester can compare against the stimulus file.
- Also usable in-design as a delta encoder. Valid/ready on both sides, one-deep registered output stage.

---
 rtl/accum_decoder.sv | 127 ++++++++++++
 tb/tb_accum_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_decoder.sv
// Delta decoder: recovers per-sample increments from an accumulated stream, with a
// one-deep registered output stage. Optional sticky wrap detector: ACCUM_DECODER_WRAP_CHECK_EN.
module accum_decoder #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_first,
  output logic [CNT_WIDTH-1:0] sample_count
`ifdef ACCUM_DECODER_WRAP_CHECK_EN
  ,
  output logic                 wrap_err
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 valid_r, valid_s;
  logic [WIDTH-1:0]     data_r, data_s;
  logic                 first_r, first_s;
  logic [WIDTH-1:0]     prev_r, prev_s;
  logic                 have_prev_r, have_prev_s;
  logic [CNT_WIDTH-1:0] cnt_r, cnt_s;
  logic                 accept_s;

  // The output slot frees up when empty or retiring this cycle; clear blocks intake.
  assign in_ready = !clear && (!valid_r || out_ready);
  assign accept_s = in_valid && in_ready;

  assign out_valid    = valid_r;
  assign out_data     = data_r;
  assign out_first    = first_r;
  assign sample_count = cnt_r;

  // Next-state for the output stage, baseline and counter.
  always_comb begin
    valid_s     = valid_r;
    data_s      = data_r;
    first_s     = first_r;
    prev_s      = prev_r;
    have_prev_s = have_prev_r;
    cnt_s       = cnt_r;
    if (clear) begin
      valid_s     = 1'b0;
      first_s     = 1'b0;
      prev_s      = {WIDTH{1'b0}};
      have_prev_s = 1'b0;
      cnt_s       = {CNT_WIDTH{1'b0}};
    end else if (accept_s) begin
      if (have_prev_r) begin
        data_s  = in_data - prev_r;
        first_s = 1'b0;
      end else begin
        data_s  = in_data;
        first_s = 1'b1;
      end
      prev_s      = in_data;
      have_prev_s = 1'b1;
      valid_s     = 1'b1;
      if (cnt_r != CNT_MAX) begin
        cnt_s = cnt_r + CNT_ONE;
      end else begin
        cnt_s = cnt_r;
      end
    end else if (out_ready) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_r     <= 1'b0;
      data_r      <= {WIDTH{1'b0}};
      first_r     <= 1'b0;
      prev_r      <= {WIDTH{1'b0}};
      have_prev_r <= 1'b0;
      cnt_r       <= {CNT_WIDTH{1'b0}};
    end else begin
      valid_r     <= valid_s;
      data_r      <= data_s;
      first_r     <= first_s;
      prev_r      <= prev_s;
      have_prev_r <= have_prev_s;
      cnt_r       <= cnt_s;
    end
  end

`ifdef ACCUM_DECODER_WRAP_CHECK_EN
  logic wrap_r, wrap_s;

  assign wrap_err = wrap_r;

  // Sticky flag: a non-first sample below its predecessor means wrap or regression.
  always_comb begin
    wrap_s = wrap_r;
    if (clear) begin
      wrap_s = 1'b0;
    end else if (accept_s && have_prev_r && (in_data < prev_r)) begin
      wrap_s = 1'b1;
    end else begin
      wrap_s = wrap_r;
    end
  end

  // Wrap flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_s;
    end
  end
`endif

endmodule

// File: tb/tb_accum_decoder.sv
// Directed plus random bench for accum_decoder (CNT_WIDTH=4) against a queue-based model
// of the accepted history.
module tb_accum_decoder;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_first;
  logic [3:0]  sample_count;
`ifdef ACCUM_DECODER_WRAP_CHECK_EN
  logic        wrap_err;
`endif

  accum_decoder #(.WIDTH(32), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .sample_count(sample_count)
`ifdef ACCUM_DECODER_WRAP_CHECK_EN
    , .wrap_err(wrap_err)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: the list of accepted samples since reset/clear plus the visible output slot.
  int unsigned hist[$];
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = 32'd0;
  logic        m_first = 1'b0;
  logic        m_wrap  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_count();
    return (hist.size() > 15) ? 32'd15 : 32'(hist.size());
  endfunction

  task automatic model_reset();
    hist.delete();
    m_valid = 1'b0;
    m_first = 1'b0;
    m_data  = 32'd0;
    m_wrap  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".data"}, out_data, m_data);
      chk({tag, ".first"}, 32'(out_first), 32'(m_first));
    end
    chk({tag, ".count"}, 32'(sample_count), exp_count());
`ifdef ACCUM_DECODER_WRAP_CHECK_EN
    chk({tag, ".wrap"}, 32'(wrap_err), 32'(m_wrap));
`endif
  endtask

  // One clock: called at a negedge, drives inputs, checks in_ready, advances, checks outputs.
  task automatic cycle(input string tag, input logic v, input logic [31:0] d,
                       input logic ordy, input logic clr, output logic acc);
    logic rdy;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    rdy = !clr && (!m_valid || ordy);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    acc = v && rdy;
    @(posedge clock);
    if (clr) begin
      model_reset();
    end else if (acc) begin
      if (hist.size() == 0) begin
        m_data  = d;
        m_first = 1'b1;
      end else begin
        m_data  = d - hist[hist.size()-1];
        m_first = 1'b0;
        if (d < hist[hist.size()-1]) m_wrap = 1'b1;
      end
      hist.push_back(d);
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(negedge clock);
    check_outputs(tag);
  endtask

  initial begin
    logic        a;
    logic        pv;
    logic [31:0] pd;
    logic [31:0] accv;
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.data", out_data, 32'd0);
    chk("reset.first", 32'(out_first), 32'd0);
    chk("reset.count", 32'(sample_count), 32'd0);

    // Ramp 1,3,6,10 -> 1,2,3,4 back-to-back
    cycle("ramp0", 1'b1, 32'd1, 1'b1, 1'b0, a);
    chk("ramp0.lit", out_data, 32'd1);
    chk("ramp0.first_lit", 32'(out_first), 32'd1);
    cycle("ramp1", 1'b1, 32'd3, 1'b1, 1'b0, a);
    chk("ramp1.lit", out_data, 32'd2);
    cycle("ramp2", 1'b1, 32'd6, 1'b1, 1'b0, a);
    chk("ramp2.lit", out_data, 32'd3);
    cycle("ramp3", 1'b1, 32'd10, 1'b1, 1'b0, a);
    chk("ramp3.lit", out_data, 32'd4);
    chk("ramp3.first_lit", 32'(out_first), 32'd0);
    chk("ramp.count_lit", 32'(sample_count), 32'd4);
    cycle("ramp_idle", 1'b0, 32'd0, 1'b1, 1'b0, a);

    // Backpressure on a fresh baseline: 5,12,20 with 3 stall cycles
    cycle("bp_clr", 1'b0, 32'd0, 1'b1, 1'b1, a);
    cycle("bp0", 1'b1, 32'd5, 1'b1, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall", 1'b1, 32'd12, 1'b0, 1'b0, a);
      chk("bp_stall.hold_lit", out_data, 32'd5);
      chk("bp_stall.rdy_lit", 32'(in_ready), 32'd0);
    end
    cycle("bp1", 1'b1, 32'd12, 1'b1, 1'b0, a);
    chk("bp1.lit", out_data, 32'd7);
    cycle("bp2", 1'b1, 32'd20, 1'b1, 1'b0, a);
    chk("bp2.lit", out_data, 32'd8);
    cycle("bp_idle", 1'b0, 32'd0, 1'b1, 1'b0, a);

    // Wrap-around decode
    cycle("wr_clr", 1'b0, 32'd0, 1'b1, 1'b1, a);
    cycle("wr0", 1'b1, 32'hFFFF_FFF0, 1'b1, 1'b0, a);
    chk("wr0.lit", out_data, 32'hFFFF_FFF0);
    cycle("wr1", 1'b1, 32'h0000_0010, 1'b1, 1'b0, a);
    chk("wr1.lit", out_data, 32'h0000_0020);
    cycle("wr_idle", 1'b0, 32'd0, 1'b1, 1'b0, a);

    // Clear mid-stream with a pending output
    cycle("cl0", 1'b1, 32'd100, 1'b1, 1'b0, a);
    cycle("cl1", 1'b1, 32'd150, 1'b0, 1'b0, a);
    cycle("cl1b", 1'b0, 32'd150, 1'b0, 1'b0, a);
    cycle("cl_clr", 1'b0, 32'd0, 1'b0, 1'b1, a);
    chk("cl_clr.valid_lit", 32'(out_valid), 32'd0);
    cycle("cl2", 1'b1, 32'd40, 1'b1, 1'b0, a);
    chk("cl2.lit", out_data, 32'd40);
    chk("cl2.first_lit", 32'(out_first), 32'd1);
    chk("cl2.count_lit", 32'(sample_count), 32'd1);

    // Async reset during a stall
    cycle("ar0", 1'b1, 32'd77, 1'b0, 1'b0, a);
    cycle("ar_stall", 1'b0, 32'd0, 1'b0, 1'b0, a);
    #2 reset_n = 1'b0;
    #1;
    chk("areset.valid", 32'(out_valid), 32'd0);
    chk("areset.count", 32'(sample_count), 32'd0);
    chk("areset.first", 32'(out_first), 32'd0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    cycle("ar1", 1'b1, 32'd9, 1'b1, 1'b0, a);
    chk("ar1.lit", out_data, 32'd9);
    chk("ar1.first_lit", 32'(out_first), 32'd1);

    // Saturation: 19 more accepts (20 total) with increments of 3
    for (int i = 1; i < 20; i++) begin
      cycle("sat", 1'b1, 32'd9 + 32'(3 * i), 1'b1, 1'b0, a);
    end
    chk("sat.count_lit", 32'(sample_count), 32'd15);
    chk("sat.data_lit", out_data, 32'd3);

    // Random traffic with held producer, random backpressure, rare clears and jumps
    pv = 1'b0; pd = 32'd0; accv = 32'd9 + 32'd57;
    for (int i = 0; i < 400; i++) begin
      logic clr;
      if (!pv) begin
        pv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) accv = $urandom();
        else accv = accv + 32'($urandom_range(0, 1000));
        pd = accv;
      end
      clr = ($urandom_range(0, 39) == 0);
      cycle("rnd", pv, pd, 1'($urandom_range(0, 1)), clr, a);
      if (a) pv = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
